// File: rtl/zrb_frame_parser_if.sv
// Byte-stream link between the frame parser and its RX/TX FIFOs.
// master = parser side (pops RX, pushes TX); slave = FIFO side.
interface zrb_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_rd;
    logic       tx_full;
    logic       tx_wr;
    logic [7:0] tx_data;

    modport master (
        input  rx_data,
        input  rx_empty,
        input  tx_full,
        output rx_rd,
        output tx_wr,
        output tx_data
    );

    modport slave (
        output rx_data,
        output rx_empty,
        output tx_full,
        input  rx_rd,
        input  tx_wr,
        input  tx_data
    );
endinterface

// File: rtl/zrb_frame_parser.sv
// SOF/CMD/LEN/payload/CHK frame parser with one ACK/NAK byte per frame; one RX byte per cycle.
// Stalls in RESP while tx_full=1; inter-byte gaps are bounded by TIMEOUT clk_en ticks.
module zrb_frame_parser #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    zrb_frame_parser_if.master         bus,
    output logic                       frame_valid,
    output logic [7:0]                 frame_cmd,
    output logic [3:0]                 frame_len,
    output logic [63:0]                frame_payload,
    output logic [7:0]                 err_cnt
);

    localparam logic [2:0] S_HUNT = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    logic [2:0]  state_q,    state_d;
    logic [7:0]  cmd_q,      cmd_d;
    logic [3:0]  len_q,      len_d;
    logic [7:0]  chk_q,      chk_d;
    logic [63:0] shadow_q,   shadow_d;
    logic [2:0]  idx_q,      idx_d;
    logic [7:0]  resp_q,     resp_d;
    logic [15:0] tmo_q,      tmo_d;
    logic [7:0]  err_q,      err_d;
    logic [7:0]  fcmd_q,     fcmd_d;
    logic [3:0]  flen_q,     flen_d;
    logic [63:0] fpay_q,     fpay_d;
    logic        fvalid_q,   fvalid_d;
    logic [7:0]  txhold_q,   txhold_d;

    logic rx_take;
    logic tx_take;
    logic nak;
    logic tmo_fire;
    logic active;

    assign rx_take = (state_q != S_RESP) && !bus.rx_empty;
    assign tx_take = (state_q == S_RESP) && !bus.tx_full;
    assign active  = (state_q == S_CMD) || (state_q == S_LEN) ||
                     (state_q == S_DATA) || (state_q == S_CHK);

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        len_d    = len_q;
        chk_d    = chk_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        resp_d   = resp_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        fcmd_d   = fcmd_q;
        flen_d   = flen_q;
        fpay_d   = fpay_q;
        fvalid_d = 1'b0;
        txhold_d = txhold_q;
        nak      = 1'b0;
        tmo_fire = 1'b0;

        case (state_q)
            S_HUNT: begin
                tmo_d = 16'd0;
                if (rx_take && bus.rx_data == SOF_BYTE) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (rx_take) begin
                    cmd_d   = bus.rx_data;
                    chk_d   = bus.rx_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_take) begin
                    if (bus.rx_data <= 8'd8) begin
                        len_d    = bus.rx_data[3:0];
                        chk_d    = chk_q ^ bus.rx_data;
                        shadow_d = 64'd0;
                        idx_d    = 3'd0;
                        state_d  = (bus.rx_data == 8'd0) ? S_CHK : S_DATA;
                    end else begin
                        resp_d  = NAK_BYTE;
                        nak     = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_DATA: begin
                if (rx_take) begin
                    shadow_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
                    chk_d = chk_q ^ bus.rx_data;
                    idx_d = idx_q + 3'd1;
                    if ({1'b0, idx_q} == len_q - 4'd1) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (rx_take) begin
                    if (bus.rx_data == chk_q) begin
                        fcmd_d   = cmd_q;
                        flen_d   = len_q;
                        fpay_d   = shadow_q;
                        fvalid_d = 1'b1;
                        resp_d   = ACK_BYTE;
                    end else begin
                        resp_d = NAK_BYTE;
                        nak    = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                tmo_d = 16'd0;
                if (tx_take) begin
                    txhold_d = resp_q;
                    state_d  = S_HUNT;
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        // A byte arriving on the expiring tick keeps the frame alive.
        if (active) begin
            if (rx_take) begin
                tmo_d = 16'd0;
            end else if (clk_en) begin
                if (tmo_q + 16'd1 == TIMEOUT) begin
                    tmo_fire = 1'b1;
                    tmo_d    = 16'd0;
                    state_d  = S_HUNT;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
        end

        if ((nak || tmo_fire) && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_HUNT;
            cmd_q    <= 8'd0;
            len_q    <= 4'd0;
            chk_q    <= 8'd0;
            shadow_q <= 64'd0;
            idx_q    <= 3'd0;
            resp_q   <= 8'd0;
            tmo_q    <= 16'd0;
            err_q    <= 8'd0;
            fcmd_q   <= 8'd0;
            flen_q   <= 4'd0;
            fpay_q   <= 64'd0;
            fvalid_q <= 1'b0;
            txhold_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            len_q    <= len_d;
            chk_q    <= chk_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            resp_q   <= resp_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            fcmd_q   <= fcmd_d;
            flen_q   <= flen_d;
            fpay_q   <= fpay_d;
            fvalid_q <= fvalid_d;
            txhold_q <= txhold_d;
        end
    end

    assign bus.rx_rd      = rx_take;
    assign bus.tx_wr      = tx_take;
    assign bus.tx_data    = tx_take ? resp_q : txhold_q;
    assign frame_valid    = fvalid_q;
    assign frame_cmd      = fcmd_q;
    assign frame_len      = flen_q;
    assign frame_payload  = fpay_q;
    assign err_cnt        = err_q;

endmodule

// File: doc/zrb_frame_parser.md
ZRB_FRAME_PARSER -- requirements
Module: zrb_frame_parser

Interface
REQ-001 Parameter TIMEOUT, default 16'd1024, number of clk_en ticks allowed between consecutive bytes of one frame.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 clk_en  in  1  timeout tick strobe (baud-rate enable), one clk wide.
REQ-005 rx_data  in  8  head byte of the upstream RX FIFO (fall-through), valid while rx_empty=0.
REQ-006 rx_empty  in  1  upstream RX FIFO empty.
REQ-007 rx_rd  out  1  pop strobe to the RX FIFO; a byte is consumed in any cycle with rx_rd=1.
REQ-008 tx_full  in  1  downstream TX FIFO full.
REQ-009 tx_wr  out  1  write strobe to the TX FIFO.
REQ-010 tx_data  out  8  response byte.
REQ-011 frame_valid  out  1  one-cycle pulse on acceptance of a good frame.
REQ-012 frame_cmd  out  8  CMD of the last good frame.
REQ-013 frame_len  out  4  LEN of the last good frame.
REQ-014 frame_payload  out  64  payload of the last good frame; byte i at [8i+7:8i].
REQ-015 err_cnt  out  8  count of rejected frames, saturating at 8'hFF.

Function
REQ-016 Frame format: SOF 8'hA5, CMD, LEN (0..8), LEN payload bytes, CHK; CHK = XOR of CMD, LEN and all payload bytes.
REQ-017 States: HUNT, CMD, LEN, DATA, CHK, RESP; HUNT after reset.
REQ-018 rx_rd = ~rx_empty in HUNT, CMD, LEN, DATA and CHK; rx_rd = 0 in RESP; rx_rd is combinational, at most one byte per cycle.
REQ-019 HUNT: a consumed byte of 8'hA5 goes to CMD; any other byte is discarded silently with no err_cnt change.
REQ-020 CMD: the consumed byte is stored as the CMD, the running checksum is initialised to it, and the state goes to LEN.
REQ-021 LEN, with LEN<=8: store LEN, XOR it into the checksum, clear the payload shadow to zero; go to DATA, or to CHK if LEN=0.
REQ-022 LEN, with LEN>8: set the response to NAK and go to RESP without consuming further bytes.
REQ-023 DATA: each byte is written to shadow byte index 0..LEN-1 in order and XORed into the checksum; after byte LEN-1 the state goes to CHK.
REQ-024 CHK, on match: in the consuming cycle, copy the shadow to frame_cmd/frame_len/frame_payload, pulse frame_valid in the next cycle, set the response to ACK 8'h06, go to RESP.
REQ-025 CHK, on mismatch: set the response to NAK 8'h15, go to RESP; frame_* outputs are unchanged.
REQ-026 Every NAK increments err_cnt by 1, saturating at 8'hFF.
REQ-027 RESP: wait while tx_full=1; in the first cycle with tx_full=0, assert tx_wr=1 for exactly one cycle with tx_data = the response byte, then go to HUNT.
REQ-028 Timeout counter (16 bit): cleared on every consumed byte and in HUNT/RESP; increments on clk_en in CMD/LEN/DATA/CHK.
REQ-029 When the timeout counter reaches TIMEOUT: go to HUNT, increment err_cnt (saturating), no TX write, frame_* unchanged.
REQ-030 If a byte is consumed in the same cycle the timeout would fire, the byte wins and the counter clears.
REQ-031 tx_data holds its last value when tx_wr=0; tx_wr never asserts outside RESP.

Reset
REQ-032 On reset assertion, all outputs go to 0 asynchronously (rx_rd=0 because the state is HUNT): tx_wr, tx_data, frame_valid, frame_cmd, frame_len, frame_payload, err_cnt.
REQ-033 Internal registers reset: state=HUNT; checksum, shadow and timeout counter = 0.
REQ-034 Reset mid-frame discards the partial frame; no response is issued for it.

Verification
REQ-035 Bytes A5 01 02 12 34 25 -> frame_valid pulse, frame_cmd=01, frame_len=2, frame_payload=64'h3412, one tx_wr with 06, err_cnt=0.
REQ-036 Bytes A5 01 02 12 34 26 -> tx_wr with 15, err_cnt=1, frame_* unchanged.
REQ-037 Bytes 00 FF A5 07 00 07 -> leading bytes dropped, ACK 06, frame_cmd=07, frame_len=0, frame_payload=0.
REQ-038 Bytes A5 01 09 -> NAK 15 immediately after LEN; a following byte A5 is parsed as a new SOF.
REQ-039 Bytes A5 01, then TIMEOUT clk_en ticks with no byte -> HUNT, err_cnt+1, no tx_wr; a complete good frame afterwards is ACKed.
REQ-040 Good frame with tx_full=1 held for 20 cycles in RESP -> rx_rd=0 and tx_wr=0 throughout; a single 06 is written on release.
